// File: rtl/inst_immediate_pkg.sv
// Shared definitions for the RV32I immediate decoder: the instruction format
// codes, the base opcode constants and the per-format immediate extractors.
package inst_immediate_pkg;

  // Instruction format code carried alongside the registered immediate.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // RV32I base opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // I-type: 12-bit signed field in inst[31:20].
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{21{inst[31]}}, inst[30:20]};
  endfunction

  // S-type: upper field inst[31:25], lower field inst[11:7].
  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{21{inst[31]}}, inst[30:25], inst[11:7]};
  endfunction

  // B-type: byte offset scaled by two, so bit 0 is always zero.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // U-type: upper 20 bits, low 12 bits cleared.
  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  // J-type: 21-bit signed jump offset, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_format_decode.sv
// Opcode classifier: maps inst[6:0] onto an instruction format code and flags
// whether the opcode belongs to the RV32I base set. Purely combinational.
module inst_format_decode
  import inst_immediate_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] fmt,
  output logic       known
);

  // Unknown opcodes fall back to R format so they select a zero immediate.
  always_comb begin
    fmt   = FMT_R;
    known = 1'b1;
    case (opcode)
      OPC_LUI,
      OPC_AUIPC:    fmt = FMT_U;
      OPC_JAL:      fmt = FMT_J;
      OPC_JALR,
      OPC_LOAD,
      OPC_OP_IMM,
      OPC_MISC_MEM,
      OPC_SYSTEM:   fmt = FMT_I;
      OPC_STORE:    fmt = FMT_S;
      OPC_BRANCH:   fmt = FMT_B;
      OPC_OP:       fmt = FMT_R;
      default: begin
        fmt   = FMT_R;
        known = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_immediate_decode.sv
// RV32I decode-stage immediate extractor. All five immediates are produced
// combinationally; the immediate matching the opcode's format is registered
// one cycle later together with the format code for the execute stage.
// Optional feature macro: INST_IMM_ILLEGAL_EN adds a registered illegal_q
// flag for opcodes outside RV32I or words without inst[1:0] == 2'b11.
module inst_immediate_decode
  import inst_immediate_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic            in_valid,
  output logic [XLEN-1:0] I_immediate,
  output logic [XLEN-1:0] S_immediate,
  output logic [XLEN-1:0] B_immediate,
  output logic [XLEN-1:0] U_immediate,
  output logic [XLEN-1:0] J_immediate,
  output logic [XLEN-1:0] imm_q,
  output logic [2:0]      fmt_q,
  output logic            out_valid
`ifdef INST_IMM_ILLEGAL_EN
  ,
  output logic            illegal_q
`endif
);

  logic        [2:0]      fmt_p0;
  logic                   known_p0;
  logic signed [XLEN-1:0] sel_imm_p0;

  // ---- stage p0: combinational extraction and format decode ----
  assign I_immediate = imm_i(inst);
  assign S_immediate = imm_s(inst);
  assign B_immediate = imm_b(inst);
  assign U_immediate = imm_u(inst);
  assign J_immediate = imm_j(inst);

  inst_format_decode u_fmt (
    .opcode (inst[6:0]),
    .fmt    (fmt_p0),
    .known  (known_p0)
  );

  // Pick the immediate for the decoded format; R and unknown opcodes give 0.
  always_comb begin
    sel_imm_p0 = '0;
    if (known_p0) begin
      case (fmt_p0)
        FMT_I:   sel_imm_p0 = I_immediate;
        FMT_S:   sel_imm_p0 = S_immediate;
        FMT_B:   sel_imm_p0 = B_immediate;
        FMT_U:   sel_imm_p0 = U_immediate;
        FMT_J:   sel_imm_p0 = J_immediate;
        default: sel_imm_p0 = '0;
      endcase
    end
  end

`ifdef INST_IMM_ILLEGAL_EN
  logic illegal_p0;
  assign illegal_p0 = !known_p0 || (inst[1:0] != 2'b11);
`endif

  // ---- stage p1: execute-stage register, reset drops any in-flight value ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      imm_q     <= '0;
      fmt_q     <= FMT_R;
`ifdef INST_IMM_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm_q     <= sel_imm_p0;
        fmt_q     <= fmt_p0;
`ifdef INST_IMM_ILLEGAL_EN
        illegal_q <= illegal_p0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_immediate_decode.sv
// Randomised scoreboard bench for inst_immediate_decode.
module tb_inst_immediate_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        in_valid;
  logic [31:0] I_immediate, S_immediate, B_immediate, U_immediate, J_immediate;
  logic [31:0] imm_q;
  logic [2:0]  fmt_q;
  logic        out_valid;
`ifdef INST_IMM_ILLEGAL_EN
  logic        illegal_q;
`endif

  inst_immediate_decode #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .in_valid    (in_valid),
    .I_immediate (I_immediate),
    .S_immediate (S_immediate),
    .B_immediate (B_immediate),
    .U_immediate (U_immediate),
    .J_immediate (J_immediate),
    .imm_q       (imm_q),
    .fmt_q       (fmt_q),
    .out_valid   (out_valid)
`ifdef INST_IMM_ILLEGAL_EN
    ,
    .illegal_q   (illegal_q)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // expected register contents as seen by the execute stage
  logic [31:0] held_imm = 32'h0;
  logic [2:0]  held_fmt = 3'd0;
  logic        held_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (inst=%h t=%0t)", name, act, exp, inst, $time);
    end
  endtask

  // ---- reference model: field values rebuilt as signed integers ----
  function automatic logic [31:0] m_i(input logic [31:0] x);
    int v;
    v = $signed(x) >>> 20;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_s(input logic [31:0] x);
    int v;
    v = ($signed(x) >>> 25) * 32 + int'(x[11:7]);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_b(input logic [31:0] x);
    int v;
    v = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_u(input logic [31:0] x);
    return x & 32'hFFFF_F000;
  endfunction

  function automatic logic [31:0] m_j(input logic [31:0] x);
    int v;
    v = (x[31] ? -1048576 : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
    return 32'(v);
  endfunction

  // format code: 0=R 1=I 2=S 3=B 4=U 5=J; known=0 for opcodes outside RV32I
  function automatic void m_fmt(input logic [31:0] x, output logic [2:0] f, output logic known);
    known = 1'b1;
    case (x[6:0])
      7'h37, 7'h17:                      f = 3'd4;
      7'h6F:                             f = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: f = 3'd1;
      7'h23:                             f = 3'd2;
      7'h63:                             f = 3'd3;
      7'h33:                             f = 3'd0;
      default: begin f = 3'd0; known = 1'b0; end
    endcase
  endfunction

  function automatic logic [31:0] m_sel(input logic [31:0] x, input logic [2:0] f);
    case (f)
      3'd1:    return m_i(x);
      3'd2:    return m_s(x);
      3'd3:    return m_b(x);
      3'd4:    return m_u(x);
      3'd5:    return m_j(x);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue the expected register state after the
  // coming edge, and check the combinational outputs for this word.
  task automatic apply(input logic r, input logic v, input logic [31:0] w);
    exp_t        e;
    logic [2:0]  f;
    logic        known;
    rst      = r;
    in_valid = v;
    inst     = w;
    m_fmt(w, f, known);
    if (r) begin
      held_imm = 32'h0;
      held_fmt = 3'd0;
      held_ill = 1'b0;
    end else if (v) begin
      held_imm = m_sel(w, f);
      held_fmt = f;
      held_ill = !known || (w[1:0] != 2'b11);
    end
    e.vld = !r && v;
    e.imm = held_imm;
    e.fmt = held_fmt;
    e.ill = held_ill;
    exp_q.push_back(e);
    #1;
    chk("I_imm", I_immediate, m_i(w));
    chk("S_imm", S_immediate, m_s(w));
    chk("B_imm", B_immediate, m_b(w));
    chk("U_imm", U_immediate, m_u(w));
    chk("J_imm", J_immediate, m_j(w));
    @(posedge clk);
    #1;
  endtask

  // ---- monitor: pops one expectation per edge, after the edge has settled ----
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", {31'b0, out_valid}, {31'b0, e.vld});
        chk("imm_q", imm_q, e.imm);
        chk("fmt_q", {29'b0, fmt_q}, {29'b0, e.fmt});
`ifdef INST_IMM_ILLEGAL_EN
        chk("illegal_q", {31'b0, illegal_q}, {31'b0, e.ill});
`endif
      end else if (out_valid === 1'b1) begin
        chk("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
      end
    end
  end

  logic [6:0] opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};

  initial begin
    logic [31:0] w;
    int          wait_cycles;
    rst      = 1'b1;
    in_valid = 1'b0;
    inst     = 32'h0;
    // reset state
    apply(1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0);
    // directed boundary words for the combinational extractors
    apply(1'b0, 1'b0, 32'h8000_0000);
    apply(1'b0, 1'b0, 32'h7FFF_FFFF);
    apply(1'b0, 1'b0, 32'h4600_0000);
    apply(1'b0, 1'b0, 32'h0000_0B00);
    apply(1'b0, 1'b0, 32'h0160_0000);
    apply(1'b0, 1'b0, 32'h0000_0080);
    apply(1'b0, 1'b0, 32'hFFFF_FFFF);
    // LUI, ADDI -1, JAL 0 then an idle cycle (hold)
    apply(1'b0, 1'b1, 32'h1234_50B7);
    apply(1'b0, 1'b1, 32'hFFF0_0093);
    apply(1'b0, 1'b1, 32'h0000_006F);
    apply(1'b0, 1'b0, 32'hFFF0_0093);
    apply(1'b0, 1'b0, 32'h0000_0000);
    // unknown opcode and R-type both select zero
    apply(1'b0, 1'b1, 32'hFFFF_FF7F);
    apply(1'b0, 1'b1, 32'hFFFF_FFB3);
    apply(1'b0, 1'b1, 32'hABCD_E063);
    // reset while valid: register cleared, combinational outputs still track
    apply(1'b1, 1'b1, 32'hFEDC_B0A3);
    apply(1'b0, 1'b1, 32'h8765_4323);
    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      w = $urandom();
      if ($urandom_range(0, 7) != 0)
        w[6:0] = opc_tab[$urandom_range(0, 11)];
      apply($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, w);
    end
    apply(1'b0, 1'b0, 32'h0);
    // drain with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #5;
    if (exp_q.size() > 0)
      chk("drain_timeout", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
